// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-BRAM port between CPU fetch (read-only) and the loader (read/write).
// Optional macro IMEM_ARB_RR_EN: round-robin tie-break in S_FETCH instead of fixed loader priority.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned TAG_W = 2;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_LOAD  = 1'b1
  } state_t;

  state_t                       state_q;
  logic   [TAG_W-1:0]           tag_q [RD_LAT];
  logic   [TAG_W-1:0]           tag_d;
  logic   [TAG_W-1:0]           tag_out;
  logic                         l_win;
  logic                         f_win;
  logic                         tie_to_loader;

`ifdef IMEM_ARB_RR_EN
  logic last_fetch_q;

  // Tie goes to whoever was not granted most recently; starts as if fetch won last.
  assign tie_to_loader = last_fetch_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_fetch_q <= 1'b1;
    end else if (l_gnt) begin
      last_fetch_q <= 1'b0;
    end else if (f_gnt) begin
      last_fetch_q <= 1'b1;
    end
  end
`else
  assign tie_to_loader = 1'b1;
`endif

  // Per-cycle arbitration; a locked port only ever serves the loader.
  always_comb begin
    l_win = 1'b0;
    f_win = 1'b0;
    if (state_q == S_LOAD) begin
      l_win = l_req;
    end else begin
      if (l_req && f_req) begin
        l_win = tie_to_loader;
      end else begin
        l_win = l_req;
      end
      f_win = f_req & ~l_win;
    end
  end

  assign l_gnt = ~reset & l_win;
  assign f_gnt = ~reset & f_win;

  assign mem_address = l_gnt ? l_addr  : f_addr;
  assign mem_data    = l_gnt ? l_wdata : DATA_W'(0);
  assign mem_wren    = l_gnt & l_we;

  // Tag is {valid, owner_is_loader}; writes enter as invalid.
  assign tag_d   = {(f_gnt | (l_gnt & ~l_we)), l_gnt};
  assign tag_out = tag_q[RD_LAT-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tag_q[i] <= TAG_W'(0);
      end
    end else begin
      case (state_q)
        S_FETCH: state_q <= l_lock ? S_LOAD : S_FETCH;
        S_LOAD:  state_q <= l_lock ? S_LOAD : S_FETCH;
        default: state_q <= S_FETCH;
      endcase
      tag_q[0] <= tag_d;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign f_rvalid = ~reset & tag_out[1] & ~tag_out[0];
  assign l_rvalid = ~reset & tag_out[1] &  tag_out[0];
  assign f_rdata  = f_rvalid ? mem_q : DATA_W'(0);
  assign l_rdata  = l_rvalid ? mem_q : DATA_W'(0);

endmodule
